// File: rtl/line_buf_reader_if.sv
// rtl/line_buf_reader_if.sv - handshake bundle between the line buffer reader and its neighbours
interface line_buf_reader_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 7
);
    logic              start;
    logic              s_valid;
    logic              s_ready;
    logic [DATA_W-1:0] s_data;
    logic              lb_write_en;
    logic [ADDR_W-1:0] lb_addr;
    logic [DATA_W-1:0] lb_wr_data;
    logic [DATA_W-1:0] lb_rd_data;
    logic              m_valid;
    logic              m_ready;
    logic [DATA_W-1:0] m_cur;
    logic [DATA_W-1:0] m_above;
    logic [ADDR_W-1:0] m_col;
    logic [7:0]        m_row;
    logic              m_first_row;
    logic              busy;
    logic              frame_done;

    modport master (
        input  start, s_valid, s_data, lb_rd_data, m_ready,
        output s_ready, lb_write_en, lb_addr, lb_wr_data,
               m_valid, m_cur, m_above, m_col, m_row, m_first_row,
               busy, frame_done
    );

    modport slave (
        output start, s_valid, s_data, lb_rd_data, m_ready,
        input  s_ready, lb_write_en, lb_addr, lb_wr_data,
               m_valid, m_cur, m_above, m_col, m_row, m_first_row,
               busy, frame_done
    );
endinterface

// File: rtl/line_buf_reader.sv
// rtl/line_buf_reader.sv - line buffer sequencer emitting vertically aligned pixel pairs
module line_buf_reader #(
    parameter int LINE_WIDTH = 76,
    parameter int IMG_HEIGHT = 57,
    parameter int DATA_W     = 32,
    parameter int ADDR_W     = 7
) (
    input  logic              clk,
    input  logic              rst,
    line_buf_reader_if.master bus
);
    typedef enum logic [1:0] {IDLE, RUN, FLUSH, DONE} state_t;

    typedef struct packed {
        logic [DATA_W-1:0] cur;
        logic [DATA_W-1:0] above;
        logic [ADDR_W-1:0] col;
        logic [7:0]        row;
        logic              first;
    } entry_t;

    localparam logic [ADDR_W-1:0] LAST_COL = ADDR_W'(LINE_WIDTH - 1);
    localparam logic [7:0]        LAST_ROW = 8'(IMG_HEIGHT - 1);

    state_t            state;
    logic [ADDR_W-1:0] col;
    logic [7:0]        row;
    logic              busy_q;
    logic              frame_done_q;

    logic              pend;
    entry_t            pend_e;

    logic [1:0]        occ;
    entry_t            head;
    entry_t            tail;

    logic              accept;
    logic              pop;
    logic [2:0]        fill_next;

    // Occupancy the FIFO will hold once the pending entry lands; keeping it
    // below 2 leaves room for the unconditional push that follows an accept.
    assign pop        = (occ != 2'd0) && bus.m_ready;
    assign fill_next  = {1'b0, occ} + {2'b00, pend} - {2'b00, pop};
    assign bus.s_ready = (state == RUN) && (fill_next < 3'd2);
    assign accept     = bus.s_valid && bus.s_ready;

    assign bus.lb_write_en = accept;
    assign bus.lb_addr     = col;
    assign bus.lb_wr_data  = bus.s_data;

    assign bus.m_valid     = (occ != 2'd0);
    assign bus.m_cur       = head.cur;
    assign bus.m_above     = head.above;
    assign bus.m_col       = head.col;
    assign bus.m_row       = head.row;
    assign bus.m_first_row = head.first;
    assign bus.busy        = busy_q;
    assign bus.frame_done  = frame_done_q;

    // Frame sequencer: column/row counters, state and the registered status flags
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            col          <= '0;
            row          <= '0;
            busy_q       <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            frame_done_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        state  <= RUN;
                        col    <= '0;
                        row    <= '0;
                        busy_q <= 1'b1;
                    end
                end
                RUN: begin
                    if (accept) begin
                        if (col == LAST_COL) begin
                            col <= '0;
                            if (row == LAST_ROW) begin
                                state <= FLUSH;
                            end else begin
                                row <= row + 8'd1;
                            end
                        end else begin
                            col <= col + 1'b1;
                        end
                    end
                end
                FLUSH: begin
                    if (!pend && occ == 2'd0) begin
                        state        <= DONE;
                        frame_done_q <= 1'b1;
                    end
                end
                DONE: begin
                    state  <= IDLE;
                    busy_q <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Pending stage: the buffer hands back the pre-write word on the negedge
    // inside the accept cycle, so it is captured together with the pixel.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pend   <= 1'b0;
            pend_e <= '0;
        end else begin
            pend <= accept;
            if (accept) begin
                pend_e.cur   <= bus.s_data;
                pend_e.above <= (row == 8'd0) ? '0 : bus.lb_rd_data;
                pend_e.col   <= col;
                pend_e.row   <= row;
                pend_e.first <= (row == 8'd0);
            end
        end
    end

    // Two-entry output FIFO: head drives m_*, tail holds the second entry
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            occ  <= 2'd0;
            head <= '0;
            tail <= '0;
        end else begin
            case ({pend, pop})
                2'b10: begin
                    if (occ == 2'd0) begin
                        head <= pend_e;
                    end else begin
                        tail <= pend_e;
                    end
                    occ <= occ + 2'd1;
                end
                2'b01: begin
                    head <= tail;
                    occ  <= occ - 2'd1;
                end
                2'b11: begin
                    if (occ == 2'd1) begin
                        head <= pend_e;
                    end else begin
                        head <= tail;
                        tail <= pend_e;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_line_buf_reader.sv
// tb/tb_line_buf_reader.sv - directed self-checking bench for line_buf_reader
module tb_line_buf_reader;
    localparam int LW = 76;
    localparam int IH = 57;

    typedef struct {
        logic [31:0] cur;
        logic [31:0] above;
        logic [6:0]  col;
        logic [7:0]  row;
        logic        first;
        int          cyc;
    } pair_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    line_buf_reader_if bus();

    line_buf_reader dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int tests = 0;
    int fails = 0;
    int cyc = 0;
    int exp_c = 0;
    int exp_r = 0;
    int first_acc_cyc = -1;
    int last_acc_cyc = -1;

    pair_t q[$];
    pair_t mon_p;
    int wr_viol = 0;
    int fd_count = 0;
    int fd_cyc = -1;
    int busy_fall_cyc = -1;
    logic busy_prev = 1'b0;
    logic [31:0] mem [LW];

    // Line buffer model: write on negedge, return the pre-write word
    always @(negedge clk) begin
        if (bus.lb_write_en) begin
            bus.lb_rd_data <= mem[bus.lb_addr];
            mem[bus.lb_addr] <= bus.lb_wr_data;
        end
    end

    always @(posedge clk) cyc <= cyc + 1;

    // Output monitor: records every pop plus frame status events
    always @(negedge clk) begin
        if (bus.m_valid && bus.m_ready) begin
            mon_p.cur   = bus.m_cur;
            mon_p.above = bus.m_above;
            mon_p.col   = bus.m_col;
            mon_p.row   = bus.m_row;
            mon_p.first = bus.m_first_row;
            mon_p.cyc   = cyc;
            q.push_back(mon_p);
        end
        if (bus.lb_write_en && !bus.s_ready) wr_viol++;
        if (bus.frame_done) begin
            fd_count++;
            fd_cyc = cyc;
        end
        if (busy_prev && !bus.busy) busy_fall_cyc = cyc;
        busy_prev = bus.busy;
    end

    function automatic logic [31:0] pix(input int r, input int c);
        return (r == 0) ? 32'(c + 100) : 32'(r * 1000 + c);
    endfunction

    task automatic do_reset();
        @(posedge clk); #1;
        rst = 1'b1; bus.s_valid = 1'b0; bus.s_data = '0; bus.start = 1'b0; bus.m_ready = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    task automatic start_frame();
        @(posedge clk); #1;
        bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        exp_c = 0;
        exp_r = 0;
    endtask

    task automatic advance();
        if (exp_c == LW - 1) begin
            exp_c = 0;
            if (exp_r < IH - 1) exp_r++;
        end else begin
            exp_c++;
        end
    endtask

    // Streams n pixels; rmode 0/1 holds m_ready, 2 randomises it
    task automatic feed(input int n, input int rmode);
        int sent = 0;
        int budget = 0;
        while (sent < n && budget < 20000) begin
            @(posedge clk); #1;
            bus.s_valid = 1'b1;
            bus.s_data  = pix(exp_r, exp_c);
            bus.m_ready = (rmode == 2) ? 1'($urandom_range(0, 1)) : 1'(rmode);
            @(negedge clk);
            if (bus.s_ready) begin
                tests++;
                if (bus.lb_addr !== 7'(exp_c) || bus.lb_write_en !== 1'b1) begin
                    fails++;
                    $display("FAIL feed_lb_port r%0d c%0d: addr=%0d we=%0d, want addr=%0d we=1",
                             exp_r, exp_c, bus.lb_addr, bus.lb_write_en, exp_c);
                end
                if (first_acc_cyc < 0) first_acc_cyc = cyc;
                last_acc_cyc = cyc;
                sent++;
                advance();
            end
            budget++;
        end
        tests++;
        if (sent != n) begin
            fails++;
            $display("FAIL feed_timeout: sent=%0d, want %0d", sent, n);
        end
        @(posedge clk); #1;
        bus.s_valid = 1'b0;
    endtask

    task automatic drain(input int target);
        for (int i = 0; i < 400 && q.size() < target; i++) begin
            @(posedge clk); #1;
            bus.m_ready = 1'b1;
        end
        repeat (4) @(posedge clk);
        #1;
    endtask

    task automatic check_pairs(input string name, input int qbase, input int gbase, input int n);
        logic [31:0] ea;
        int r;
        int c;
        for (int k = 0; k < n && (qbase + k) < q.size(); k++) begin
            r  = (gbase + k) / LW;
            c  = (gbase + k) % LW;
            ea = (r == 0) ? 32'd0 : pix(r - 1, c);
            tests++;
            if (q[qbase+k].cur !== pix(r, c) || q[qbase+k].above !== ea || q[qbase+k].col !== 7'(c) ||
                q[qbase+k].row !== 8'(r) || q[qbase+k].first !== (r == 0)) begin
                fails++;
                $display("FAIL %s pair%0d: cur=%0d above=%0d col=%0d row=%0d first=%0d, want cur=%0d above=%0d col=%0d row=%0d first=%0d",
                         name, k, q[qbase+k].cur, q[qbase+k].above, q[qbase+k].col, q[qbase+k].row,
                         q[qbase+k].first, pix(r, c), ea, c, r, (r == 0));
            end
        end
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clk);
        tests++;
        if ({bus.s_ready, bus.lb_write_en, bus.lb_addr, bus.lb_wr_data, bus.m_valid, bus.m_first_row,
             bus.busy, bus.frame_done} !== '0) begin
            fails++;
            $display("FAIL reset_ctrl: s_ready=%0d we=%0d addr=%0d wd=%0d m_valid=%0d first=%0d busy=%0d fd=%0d, want all 0",
                     bus.s_ready, bus.lb_write_en, bus.lb_addr, bus.lb_wr_data, bus.m_valid,
                     bus.m_first_row, bus.busy, bus.frame_done);
        end
        tests++;
        if ({bus.m_cur, bus.m_above, bus.m_col, bus.m_row} !== '0) begin
            fails++;
            $display("FAIL reset_data: cur=%0d above=%0d col=%0d row=%0d, want all 0",
                     bus.m_cur, bus.m_above, bus.m_col, bus.m_row);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        tests++;
        if (bus.busy !== 1'b0 || bus.s_ready !== 1'b0) begin
            fails++;
            $display("FAIL idle_after_reset: busy=%0d s_ready=%0d, want 0 0", bus.busy, bus.s_ready);
        end
    endtask

    task automatic test_mid_frame_reset();
        int fd0;
        start_frame();
        feed(10, 1);
        fd0 = fd_count;
        @(negedge clk); #2;
        rst = 1'b1;
        bus.s_data = '0;
        #1;
        tests++;
        if ({bus.s_ready, bus.lb_write_en, bus.lb_addr, bus.lb_wr_data, bus.m_valid, bus.m_cur, bus.m_above,
             bus.m_col, bus.m_row, bus.m_first_row, bus.busy, bus.frame_done} !== '0) begin
            fails++;
            $display("FAIL async_reset_outputs: busy=%0d m_valid=%0d addr=%0d cur=%0d, want all outputs 0",
                     bus.busy, bus.m_valid, bus.lb_addr, bus.m_cur);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        repeat (5) @(negedge clk);
        tests++;
        if (fd_count !== fd0 || bus.m_valid !== 1'b0) begin
            fails++;
            $display("FAIL reset_no_done: frame_done pulses=%0d m_valid=%0d, want 0 0", fd_count - fd0, bus.m_valid);
        end
        start_frame();
        @(negedge clk);
        tests++;
        if (bus.busy !== 1'b1 || bus.lb_addr !== 7'd0 || bus.s_ready !== 1'b1) begin
            fails++;
            $display("FAIL restart: busy=%0d addr=%0d s_ready=%0d, want 1 0 1", bus.busy, bus.lb_addr, bus.s_ready);
        end
        do_reset();
    endtask

    task automatic test_row0_stream();
        int qb;
        do_reset();
        start_frame();
        qb = q.size();
        first_acc_cyc = -1;
        feed(LW, 1);
        drain(qb + LW);
        tests++;
        if (q.size() != qb + LW) begin
            fails++;
            $display("FAIL row0_count: got %0d pairs, want %0d", q.size() - qb, LW);
        end else begin
            tests++;
            if (q[qb].cyc - first_acc_cyc != 2) begin
                fails++;
                $display("FAIL row0_latency: %0d cycles, want 2", q[qb].cyc - first_acc_cyc);
            end
            tests++;
            if (last_acc_cyc - first_acc_cyc != LW - 1 || q[qb+LW-1].cyc - q[qb].cyc != LW - 1) begin
                fails++;
                $display("FAIL row0_back_to_back: accept span=%0d pop span=%0d, want %0d %0d",
                         last_acc_cyc - first_acc_cyc, q[qb+LW-1].cyc - q[qb].cyc, LW - 1, LW - 1);
            end
            check_pairs("row0", qb, 0, LW);
        end
    endtask

    task automatic test_vertical();
        int qb;
        qb = q.size();
        feed(2 * LW, 1);
        drain(qb + 2 * LW);
        tests++;
        if (q.size() != qb + 2 * LW) begin
            fails++;
            $display("FAIL vertical_count: got %0d pairs, want %0d", q.size() - qb, 2 * LW);
        end
        check_pairs("vertical", qb, LW, 2 * LW);
    endtask

    task automatic test_col_wrap();
        int qb;
        qb = q.size();
        feed(LW - 1, 1);
        @(posedge clk); #1;
        bus.s_valid = 1'b1;
        bus.s_data  = pix(3, 75);
        @(negedge clk);
        tests++;
        if (bus.s_ready !== 1'b1 || bus.lb_addr !== 7'd75) begin
            fails++;
            $display("FAIL wrap_last_col: s_ready=%0d addr=%0d, want 1 75", bus.s_ready, bus.lb_addr);
        end
        @(posedge clk); #1;
        bus.s_data = pix(4, 0);
        @(negedge clk);
        tests++;
        if (bus.s_ready !== 1'b1 || bus.lb_addr !== 7'd0) begin
            fails++;
            $display("FAIL wrap_next_addr: s_ready=%0d addr=%0d, want 1 0", bus.s_ready, bus.lb_addr);
        end
        @(posedge clk); #1;
        bus.s_valid = 1'b0;
        exp_c = 1;
        exp_r = 4;
        drain(qb + LW + 1);
        tests++;
        if (q.size() != qb + LW + 1) begin
            fails++;
            $display("FAIL wrap_count: got %0d pairs, want %0d", q.size() - qb, LW + 1);
        end
        check_pairs("wrap", qb, 3 * LW, LW + 1);
    endtask

    task automatic test_backpressure();
        int qb;
        int acc = 0;
        int w0;
        bit seen = 0;
        bit stable = 1;
        logic [31:0] snap_cur;
        logic [6:0] snap_col;
        qb = q.size();
        w0 = wr_viol;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #1;
            bus.s_valid = 1'b1;
            bus.s_data  = pix(exp_r, exp_c);
            bus.m_ready = 1'b0;
            @(negedge clk);
            if (bus.m_valid) begin
                if (!seen) begin
                    seen = 1;
                    snap_cur = bus.m_cur;
                    snap_col = bus.m_col;
                end else if (bus.m_cur !== snap_cur || bus.m_col !== snap_col) begin
                    stable = 0;
                end
            end
            if (bus.s_ready) begin
                acc++;
                advance();
            end
        end
        tests++;
        if (acc != 2 || bus.s_ready !== 1'b0) begin
            fails++;
            $display("FAIL bp_accepts: got %0d accepts s_ready=%0d, want 2 0", acc, bus.s_ready);
        end
        tests++;
        if (!seen || !stable) begin
            fails++;
            $display("FAIL bp_hold: seen=%0d stable=%0d, want 1 1", seen, stable);
        end
        @(posedge clk); #1;
        bus.s_valid = 1'b0;
        drain(qb + 2);
        tests++;
        if (q.size() != qb + 2 || wr_viol != w0) begin
            fails++;
            $display("FAIL bp_release: pairs=%0d write_violations=%0d, want 2 0", q.size() - qb, wr_viol - w0);
        end
        check_pairs("bp", qb, 4 * LW + 1, 2);
    endtask

    task automatic test_frame_end();
        int qb;
        int fd0;
        int last;
        do_reset();
        start_frame();
        qb = q.size();
        fd0 = fd_count;
        feed(1000, 2);
        @(posedge clk); #1;
        bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        @(negedge clk);
        tests++;
        if (bus.busy !== 1'b1 || bus.lb_addr !== 7'd12) begin
            fails++;
            $display("FAIL start_ignored: busy=%0d addr=%0d, want 1 12", bus.busy, bus.lb_addr);
        end
        feed(LW * IH - 1000, 2);
        drain(qb + LW * IH);
        last = q.size() - 1;
        tests++;
        if (q.size() != qb + LW * IH) begin
            fails++;
            $display("FAIL frame_count: got %0d pairs, want %0d", q.size() - qb, LW * IH);
        end
        check_pairs("frame", qb, 0, LW * IH);
        tests++;
        if (q[last].col !== 7'd75 || q[last].row !== 8'd56) begin
            fails++;
            $display("FAIL final_pair: col=%0d row=%0d, want 75 56", q[last].col, q[last].row);
        end
        tests++;
        if (fd_count != fd0 + 1 || fd_cyc != q[last].cyc + 2 || busy_fall_cyc != fd_cyc + 1) begin
            fails++;
            $display("FAIL frame_done: pulses=%0d fd_delay=%0d busy_delay=%0d, want 1 2 1",
                     fd_count - fd0, fd_cyc - q[last].cyc, busy_fall_cyc - fd_cyc);
        end
        tests++;
        if (bus.busy !== 1'b0 || bus.s_ready !== 1'b0 || bus.m_valid !== 1'b0) begin
            fails++;
            $display("FAIL after_frame: busy=%0d s_ready=%0d m_valid=%0d, want 0 0 0",
                     bus.busy, bus.s_ready, bus.m_valid);
        end
    endtask

    initial begin
        bus.start   = 1'b0;
        bus.s_valid = 1'b0;
        bus.s_data  = '0;
        bus.m_ready = 1'b0;
        test_reset();
        test_mid_frame_reset();
        test_row0_stream();
        test_vertical();
        test_col_wrap();
        test_backpressure();
        test_frame_end();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/line_buf_reader.md
Name: line_buf_reader

Overview:
- Sequencer and consumer for the 76-entry pixel line buffer.
- Accepts a raster pixel stream and drives the buffer's write_en/wr_addr/wr_data port with one write per pixel at the current column.
- Captures the returned previous-line pixel and emits vertically aligned pairs (current, above) with row/column tags to the edge-detection kernel.
- Handles frame sequencing and output backpressure.

Parameters:
- LINE_WIDTH, 76, pixels per line; line buffer depth.
- IMG_HEIGHT, 57, lines per frame.
- DATA_W, 32, pixel word width.
- ADDR_W, 7, line buffer address width.

Ports:
- clk  in  1  system clock; all state on posedge.
- rst  in  1  asynchronous reset, active-high.
- start  in  1  one-cycle pulse; begins a frame when IDLE.
- s_valid  in  1  input pixel valid.
- s_ready  out  1  input pixel accepted when s_valid && s_ready.
- s_data  in  DATA_W  input pixel.
- lb_write_en  out  1  line buffer write enable.
- lb_addr  out  ADDR_W  line buffer address (column).
- lb_wr_data  out  DATA_W  line buffer write data.
- lb_rd_data  in  DATA_W  line buffer read data.
- m_valid  out  1  output pair valid.
- m_ready  in  1  downstream accept.
- m_cur  out  DATA_W  current pixel.
- m_above  out  DATA_W  same column, previous line.
- m_col  out  ADDR_W  column of m_cur.
- m_row  out  8  row of m_cur.
- m_first_row  out  1  high when m_row==0; m_above forced 0.
- busy  out  1  high when not IDLE.
- frame_done  out  1  one-cycle pulse at frame completion.

Behaviour:

Reset (asynchronous):
- State IDLE, col=0, row=0, pend=0, output FIFO empty.
- s_ready=0, lb_write_en=0, lb_addr=0, lb_wr_data=0, m_valid=0, m_cur=0, m_above=0, m_col=0, m_row=0, m_first_row=0, busy=0, frame_done=0.
- Reset mid-frame discards all in-flight data; no frame_done is issued.

State machine:
- IDLE: wait for start.
  - start -> RUN; col=0, row=0.
  - start is ignored outside IDLE.
- RUN: accept pixels. After the accept at col==LINE_WIDTH-1, row==IMG_HEIGHT-1 -> FLUSH.
- FLUSH: s_ready=0. When pend==0 and the FIFO is empty -> DONE.
- DONE: frame_done=1 for exactly one cycle -> IDLE.
- busy = (state != IDLE).

Line buffer port:
- lb_write_en = s_valid && s_ready (combinational).
- lb_wr_data = s_data.
- lb_addr = col.
- The buffer updates on negedge and returns the pre-write contents of lb_addr. The old value of memory[col] is therefore valid on lb_rd_data at the posedge following the accept.

Counters:
- On accept, col increments.
- col==LINE_WIDTH-1 wraps to 0 and row increments.
- row never exceeds IMG_HEIGHT-1.

Pipeline, latency 2 cycles accept -> m_valid with an empty FIFO:
- Accept cycle: pend=1; latch cur pixel, col, row into pend regs.
- Next posedge: pend entry plus lb_rd_data (or 0 if row==0) is pushed unconditionally into a 2-entry output FIFO; pend clears unless a new accept occurred the same cycle.
- lb_rd_data is never sampled at any other time.

Output interface:
- m_* reflect the FIFO head; m_valid = FIFO non-empty.
- Pop on m_valid && m_ready.
- m_* hold stable while m_valid && !m_ready.

Flow control:
- s_ready = (state==RUN) && (occ + pend - pop) < 2, where occ = FIFO occupancy and pop = m_valid && m_ready.
- Guarantees the unconditional push never overflows.
- Sustained 1 pixel/cycle when m_ready is held high.

Simultaneous events:
- Push and pop in the same cycle: occupancy unchanged, ordering preserved.
- Accept on the last pixel of the frame: FLUSH is entered the next cycle, and the final pair still emerges.

Test Plan:
1. Reset mid-frame:
   - Stimulus: start, feed 10 pixels, assert rst asynchronously between edges.
   - Response: all outputs 0 immediately, state IDLE, no frame_done.
   - Next start: col=0, row=0.
2. Row 0 streaming:
   - Stimulus: start, s_valid=1, s_data=col+100, m_ready=1.
   - Response: lb_addr steps 0..75 and lb_write_en=1 each cycle.
   - First m_valid 2 cycles after first accept, then 76 pairs back-to-back with m_above=0 and m_first_row=1.
3. Vertical alignment:
   - Stimulus: row r pixel = r*1000+col, over 3 rows.
   - Response: on row 2, m_cur=2000+col and m_above=1000+col for every col, m_row=2.
4. Backpressure:
   - Stimulus: m_ready=0 while streaming.
   - Response: after exactly 2 accepts s_ready falls; m_* hold stable.
   - Release m_ready: pairs emerge in order, none lost or duplicated, lb_write_en never asserted while s_ready=0.
5. Frame end:
   - Stimulus: full 76x57 frame with random m_ready.
   - Response: 4332 pairs, final pair col=75 row=56.
   - frame_done pulses one cycle after the FIFO drains; busy falls the cycle after; start during RUN is ignored.
6. Column wrap:
   - Stimulus: accept at col=75 with s_valid held.
   - Response: next lb_addr=0, row increments, and the pair for col=75 carries the old row number.
